// File: rtl/gmii_rx_fifo_writer.sv
// GMII receive front end: packs each received byte into a {dv, er, data} word for the
// passthrough FIFO, admitting whole frames only and padding every frame with idle words.
module gmii_rx_fifo_writer #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter logic [7:0]  ADMIT_THRESH = 8'd64,
   parameter logic [7:0]  ABORT_THRESH = 8'd250,
   parameter int unsigned TAIL_WORDS   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  gmii_rx_dv,
   input  logic                  gmii_rx_er,
   input  logic [DATA_WIDTH-1:0] gmii_rxd,
   input  logic [7:0]            wrusedw,
   input  logic                  fifo_full,
   output logic                  wrreq,
   output logic [DATA_WIDTH+1:0] wrdata,
   output logic [15:0]           frame_pass_cnt,
   output logic [15:0]           frame_drop_cnt,
   output logic [15:0]           frame_trunc_cnt
);

   localparam int unsigned WORD_W    = DATA_WIDTH + 2;
   localparam logic [3:0]  TAIL_LAST = 4'(TAIL_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PASS  = 3'd1,
      S_TRUNC = 3'd2,
      S_DROP  = 3'd3,
      S_TAIL  = 3'd4
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            tail_cnt;
   logic [3:0]            tail_nxt;

   logic                  r_dv;
   logic                  r_er;
   logic [DATA_WIDTH-1:0] r_d;
   logic                  r_valid;
   logic                  prev_dv;

   logic                  start;
   logic                  frame_end;
   logic                  admit;
   logic                  abort;
   logic                  inc_pass;
   logic                  inc_drop;
   logic                  inc_trunc;
   logic                  wr_nxt;
   logic [WORD_W-1:0]     wdata_nxt;

   // r_valid holds prev_dv high for the first sampled cycle after reset, so a frame
   // already on the wire at release is seen as mid-frame rather than as a fresh start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dv    <= 1'b0;
         r_er    <= 1'b0;
         r_d     <= '0;
         r_valid <= 1'b0;
         prev_dv <= 1'b1;
      end else begin
         r_dv    <= gmii_rx_dv;
         r_er    <= gmii_rx_er;
         r_d     <= gmii_rxd;
         r_valid <= 1'b1;
         prev_dv <= r_valid ? r_dv : 1'b1;
      end
   end

   assign start     = r_dv & ~prev_dv;
   assign frame_end = ~r_dv & prev_dv;
   assign admit     = start & (wrusedw < ADMIT_THRESH) & ~fifo_full;
   assign abort     = (wrusedw >= ABORT_THRESH) | fifo_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         tail_cnt <= '0;
      end else begin
         state    <= state_nxt;
         tail_cnt <= tail_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tail_nxt  = tail_cnt;
      inc_pass  = 1'b0;
      inc_drop  = 1'b0;
      inc_trunc = 1'b0;
      case (state)
         S_IDLE: begin
            if (admit) begin
               state_nxt = S_PASS;
            end else if (r_dv) begin
               // refused start, or a frame whose beginning was never seen
               state_nxt = S_DROP;
               inc_drop  = 1'b1;
            end
         end
         S_PASS: begin
            if (r_dv) begin
               if (abort) begin
                  state_nxt = S_TRUNC;
                  inc_trunc = 1'b1;
               end
            end else begin
               state_nxt = S_TAIL;
               tail_nxt  = fifo_full ? 4'd0 : 4'd1;
               inc_pass  = 1'b1;
            end
         end
         S_TRUNC: begin
            if (!r_dv) begin
               state_nxt = S_TAIL;
               tail_nxt  = fifo_full ? 4'd0 : 4'd1;
            end
         end
         S_DROP: begin
            if (!r_dv) state_nxt = S_IDLE;
         end
         S_TAIL: begin
            if (!fifo_full) begin
               if (tail_cnt >= TAIL_LAST) state_nxt = S_IDLE;
               else                       tail_nxt  = tail_cnt + 4'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The error-marked word may land while fifo_full is high only in theory; it is
   // suppressed then, relying on the abort threshold to leave room in practice.
   always_comb begin
      wr_nxt    = 1'b0;
      wdata_nxt = '0;
      case (state)
         S_IDLE: begin
            if (admit) begin
               wr_nxt    = 1'b1;
               wdata_nxt = {1'b1, r_er, r_d};
            end
         end
         S_PASS: begin
            if (r_dv) begin
               if (abort) begin
                  wr_nxt    = ~fifo_full;
                  wdata_nxt = {1'b1, 1'b1, r_d};
               end else begin
                  wr_nxt    = 1'b1;
                  wdata_nxt = {1'b1, r_er, r_d};
               end
            end else begin
               wr_nxt = ~fifo_full;
            end
         end
         S_TRUNC: wr_nxt = frame_end & ~fifo_full;
         S_TAIL:  wr_nxt = ~fifo_full;
         default: wr_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrreq           <= 1'b0;
         wrdata          <= '0;
         frame_pass_cnt  <= '0;
         frame_drop_cnt  <= '0;
         frame_trunc_cnt <= '0;
      end else begin
         wrreq  <= wr_nxt;
         wrdata <= wdata_nxt;
         if (inc_pass && frame_pass_cnt != 16'hFFFF)
            frame_pass_cnt <= frame_pass_cnt + 16'd1;
         if (inc_drop && frame_drop_cnt != 16'hFFFF)
            frame_drop_cnt <= frame_drop_cnt + 16'd1;
         if (inc_trunc && frame_trunc_cnt != 16'hFFFF)
            frame_trunc_cnt <= frame_trunc_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_gmii_rx_fifo_writer.sv
// Directed bench for gmii_rx_fifo_writer: FIFO writes are captured and compared
// against hand-built expected word lists and frame counters.
module tb_gmii_rx_fifo_writer;

   localparam int DW = 8;
   localparam int WW = DW + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          gmii_rx_dv;
   logic          gmii_rx_er;
   logic [DW-1:0] gmii_rxd;
   logic [7:0]    wrusedw;
   logic          fifo_full;
   logic          wrreq;
   logic [WW-1:0] wrdata;
   logic [15:0]   frame_pass_cnt;
   logic [15:0]   frame_drop_cnt;
   logic [15:0]   frame_trunc_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;

   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] cap_q[$];
   int            cap_cyc[$];
   logic [15:0]   exp_pass = 16'd0;
   logic [15:0]   exp_drop = 16'd0;
   logic [15:0]   exp_trunc = 16'd0;

   gmii_rx_fifo_writer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .gmii_rx_dv      (gmii_rx_dv),
      .gmii_rx_er      (gmii_rx_er),
      .gmii_rxd        (gmii_rxd),
      .wrusedw         (wrusedw),
      .fifo_full       (fifo_full),
      .wrreq           (wrreq),
      .wrdata          (wrdata),
      .frame_pass_cnt  (frame_pass_cnt),
      .frame_drop_cnt  (frame_drop_cnt),
      .frame_trunc_cnt (frame_trunc_cnt)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wrreq) begin
         cap_q.push_back(wrdata);
         cap_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         gmii_rx_dv = 1'b0;
         gmii_rx_er = 1'b0;
         gmii_rxd   = '0;
      end
   endtask

   // usedw_at: wrusedw jumps to 250 while driving byte usedw_at+1, i.e. when byte
   // usedw_at sits in the input register and the writer compares the fill level.
   task automatic drive_frame(input int len, input logic [7:0] base, input int er_at,
                              input int usedw_at);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         if (i == 0) start_cyc = cyc;
         if (i == usedw_at) wrusedw = 8'd250;
         gmii_rx_dv = 1'b1;
         gmii_rx_er = (i + 1 == er_at);
         gmii_rxd   = base + 8'(i);
      end
   endtask

   task automatic clear_queues();
      cap_q.delete();
      cap_cyc.delete();
      exp_q.delete();
   endtask

   // scoreboard: expected words of one admitted frame plus its four idle words
   task automatic exp_frame(input int len, input logic [7:0] base, input int er_at,
                            input int trunc_at);
      logic [7:0] d;
      for (int k = 1; k <= len; k++) begin
         d = base + 8'(k - 1);
         if (k == trunc_at) begin
            exp_q.push_back({2'b11, d});
            break;
         end
         exp_q.push_back({1'b1, (k == er_at), d});
      end
      for (int k = 0; k < 4; k++) exp_q.push_back('0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = '0;
      wrusedw = 8'd0; fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (wrreq !== 1'b0) begin
         errors++; $display("FAIL reset_wrreq: got %b want 0", wrreq);
      end
      checks++;
      if (wrdata !== '0) begin
         errors++; $display("FAIL reset_wrdata: got %h want 000", wrdata);
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== 48'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                  frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt);
      end
      rst_n = 1'b1;
      idle(5);
   endtask

   task automatic test_pass_64();
      clear_queues();
      drive_frame(64, 8'h00, 0, -1);
      idle(20);
      exp_frame(64, 8'h00, 0, 0);
      exp_pass++;
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL pass64_len: got %0d words want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL pass64_word[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if (cap_cyc.size() == 0 || cap_cyc[0] - start_cyc != 2) begin
         errors++;
         $display("FAIL pass64_latency: got %0d want 2",
                  cap_cyc.size() == 0 ? -1 : cap_cyc[0] - start_cyc);
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL pass64_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
   endtask

   task automatic test_admit_thresh();
      clear_queues();
      wrusedw = 8'd64;
      drive_frame(20, 8'h40, 0, -1);
      idle(20);
      exp_drop++;
      checks++;
      if (cap_q.size() !== 0) begin
         errors++; $display("FAIL admit_drop_len: got %0d words want 0", cap_q.size());
      end
      checks++;
      if (frame_drop_cnt !== exp_drop) begin
         errors++; $display("FAIL admit_drop_cnt: got %0d want %0d", frame_drop_cnt, exp_drop);
      end
      wrusedw = 8'd10;
      drive_frame(20, 8'h60, 0, -1);
      idle(20);
      wrusedw = 8'd0;
      exp_frame(20, 8'h60, 0, 0);
      exp_pass++;
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL admit_pass_len: got %0d words want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL admit_pass_word[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL admit_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
   endtask

   task automatic test_full_drop();
      clear_queues();
      fifo_full = 1'b1;
      drive_frame(8, 8'hA0, 0, -1);
      idle(20);
      fifo_full = 1'b0;
      exp_drop++;
      checks++;
      if (cap_q.size() !== 0) begin
         errors++; $display("FAIL full_drop_len: got %0d words want 0", cap_q.size());
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL full_drop_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
   endtask

   task automatic test_truncate();
      clear_queues();
      drive_frame(100, 8'h01, 0, 30);
      idle(20);
      wrusedw = 8'd0;
      exp_frame(100, 8'h01, 0, 30);
      exp_trunc++;
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL trunc_len: got %0d words want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL trunc_word[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL trunc_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
   endtask

   task automatic test_rx_error();
      clear_queues();
      drive_frame(20, 8'hC0, 10, -1);
      idle(20);
      exp_frame(20, 8'hC0, 10, 0);
      exp_pass++;
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL rxer_len: got %0d words want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rxer_word[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL rxer_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
   endtask

   task automatic test_one_byte();
      clear_queues();
      drive_frame(1, 8'h5A, 0, -1);
      idle(20);
      exp_frame(1, 8'h5A, 0, 0);
      exp_pass++;
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL onebyte_len: got %0d words want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL onebyte_word[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if (frame_pass_cnt !== exp_pass) begin
         errors++; $display("FAIL onebyte_pass_cnt: got %0d want %0d", frame_pass_cnt, exp_pass);
      end
   endtask

   task automatic test_false_carrier();
      clear_queues();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         gmii_rx_dv = 1'b0;
         gmii_rx_er = 1'b1;
         gmii_rxd   = 8'h0F;
      end
      idle(10);
      checks++;
      if (cap_q.size() !== 0) begin
         errors++; $display("FAIL carrier_len: got %0d words want 0", cap_q.size());
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL carrier_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
   endtask

   task automatic test_back_to_back();
      clear_queues();
      drive_frame(10, 8'h10, 0, -1);
      idle(2);
      drive_frame(10, 8'h20, 0, -1);
      idle(12);
      drive_frame(10, 8'h30, 0, -1);
      idle(20);
      exp_frame(10, 8'h10, 0, 0);
      exp_frame(10, 8'h30, 0, 0);
      exp_pass = exp_pass + 16'd2;
      exp_drop++;
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL b2b_len: got %0d words want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_word[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL b2b_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_queues();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (i == 4) rst_n = 1'b0;
         if (i == 7) begin
            rst_n = 1'b1;
            cap_q.delete();
            cap_cyc.delete();
         end
         gmii_rx_dv = 1'b1;
         gmii_rx_er = 1'b0;
         gmii_rxd   = 8'h80 + 8'(i);
         if (i == 5) begin
            checks++;
            if (wrreq !== 1'b0 || wrdata !== '0) begin
               errors++; $display("FAIL rstmid_outputs: got wrreq=%b wrdata=%h want 0/000", wrreq, wrdata);
            end
            checks++;
            if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== 48'd0) begin
               errors++;
               $display("FAIL rstmid_counters_in_reset: got %0d/%0d/%0d want 0/0/0",
                        frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt);
            end
         end
      end
      idle(20);
      exp_pass = 16'd0; exp_drop = 16'd1; exp_trunc = 16'd0;
      checks++;
      if (cap_q.size() !== 0) begin
         errors++; $display("FAIL rstmid_len: got %0d words want 0", cap_q.size());
      end
      checks++;
      if ({frame_pass_cnt, frame_drop_cnt, frame_trunc_cnt} !== {exp_pass, exp_drop, exp_trunc}) begin
         errors++;
         $display("FAIL rstmid_counters: got %0d/%0d/%0d want %0d/%0d/%0d", frame_pass_cnt,
                  frame_drop_cnt, frame_trunc_cnt, exp_pass, exp_drop, exp_trunc);
      end
      clear_queues();
      drive_frame(12, 8'hE0, 0, -1);
      idle(20);
      exp_frame(12, 8'hE0, 0, 0);
      exp_pass++;
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL rstmid_next_len: got %0d words want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rstmid_next_word[%0d]: got %h want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if (frame_pass_cnt !== exp_pass) begin
         errors++; $display("FAIL rstmid_next_pass_cnt: got %0d want %0d", frame_pass_cnt, exp_pass);
      end
   endtask

   initial begin
      test_reset();
      test_pass_64();
      test_admit_thresh();
      test_full_drop();
      test_truncate();
      test_rx_error();
      test_one_byte();
      test_false_carrier();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
